// File: rtl/mips_fetch.sv
// rtl/mips_fetch.sv - MIPS instruction-fetch stage: PC, single-outstanding imem fetch, next-PC select
// State-decoded handshake outputs; next PC is resolved when execute retires the held instruction.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [1:0]  control_type,
  input  logic [31:0] rs_data,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] CT_FALL = 2'b00;
  localparam logic [1:0] CT_BR   = 2'b01;
  localparam logic [1:0] CT_J    = 2'b10;
  localparam logic [1:0] CT_JR   = 2'b11;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] inst_q, inst_nxt;
  logic [31:0] inst_pc_q, inst_pc_nxt;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        jr_misaligned;

  // Target candidates are derived from the held instruction, never from imem_rdata.
  always_comb begin
    pc4    = inst_pc_q + 32'd4;
    br_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    target = pc4;
    case (control_type)
      CT_FALL: target = pc4;
      CT_BR:   target = pc4 + br_off;
      CT_J:    target = {pc4[31:28], inst_q[25:0], 2'b00};
      CT_JR:   target = rs_data;
      default: target = pc4;
    endcase
    jr_misaligned = (control_type == CT_JR) && (rs_data[1:0] != 2'b00);
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    inst_nxt    = inst_q;
    inst_pc_nxt = inst_pc_q;
    case (state)
      S_FETCH: begin
        if (imem_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          inst_nxt    = imem_rdata;
          inst_pc_nxt = pc_q;
          state_nxt   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          if (jr_misaligned) begin
            state_nxt = S_FAULT;
          end else begin
            pc_nxt    = target;
            state_nxt = S_FETCH;
          end
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      inst_q    <= inst_nxt;
      inst_pc_q <= inst_pc_nxt;
    end
  end

  // Handshake and status outputs come straight from registers only.
  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state == S_HOLD);
  assign fault      = (state == S_FAULT);
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign opcode     = inst_q[31:26];
  assign funct      = inst_q[5:0];

endmodule

// File: doc/mips_fetch.md
# mips_fetch

Instruction-fetch stage directly upstream of the MIPS decoder. It owns the program counter, fetches one instruction at a time over a request/response instruction-memory handshake, and holds it stable for decode and execute. It computes the next PC from the decoder's `control_type` encoding (fallthrough, branch, jump, jump-register) once execute retires the instruction. It also exposes the `opcode`/`funct` fields the decoder consumes.

## Interface
- `RESET_PC`, 32'h0040_0000, PC loaded on reset; must be word-aligned.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; equals `pc` whenever `imem_req`=1.
- `imem_ready`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  fetched instruction word.
- `pc`  out  32  current PC register.
- `inst`  out  32  held instruction.
- `inst_pc`  out  32  address of `inst`.
- `opcode`  out  6  `inst[31:26]`.
- `funct`  out  6  `inst[5:0]`.
- `inst_valid`  out  1  `inst` is valid for decode/execute.
- `inst_ready`  in  1  execute retires `inst` this cycle.
- `control_type`  in  2  from decoder: 00 fallthrough, 01 branch, 10 jump, 11 jump register.
- `rs_data`  in  32  register-file rs value, the jr target.
- `fault`  out  1  sticky misaligned-jr fault.

## Operation
- FSM states: FETCH, WAIT, HOLD, FAULT.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready`=1, go to WAIT. Otherwise stay, with address held.
- WAIT: `imem_req`=0. On `imem_rvalid`=1, capture `inst`←`imem_rdata` and `inst_pc`←`pc`, then go to HOLD.
- HOLD: `inst_valid`=1. `inst`, `inst_pc`, `opcode` and `funct` are stable until retire. On `inst_ready`=1, load `pc`←next_pc and go to FETCH, except when the jr target is misaligned.
- next_pc, with pc4 = `inst_pc`+4 (mod 2^32):
  - 00: pc4.
  - 01: pc4 + (sext(`inst[15:0]`)<<2), mod 2^32.
  - 10: {pc4[31:28], `inst[25:0]`, 2'b00}.
  - 11: `rs_data`.
- Misaligned jr: in HOLD with `inst_ready`=1, `control_type`=11 and `rs_data[1:0]`≠0:
  - go to FAULT; `pc` unchanged; `fault`←1.
- FAULT: `imem_req`=0, `inst_valid`=0, `fault`=1. Only `reset` exits.
- `imem_rvalid` outside WAIT is ignored. This covers stale responses after reset.
- `inst_ready`, `control_type` and `rs_data` are ignored outside HOLD.
- One outstanding request maximum.

## Timing
- Reset (cycle with `reset`=1) sets:
  - state=FETCH, `pc`=`RESET_PC`.
  - `inst`=0, `inst_pc`=0, `inst_valid`=0, `fault`=0.
- First cycle after reset deasserts: `imem_req`=1, `imem_addr`=`RESET_PC`.
- `reset` overrides every other input in any state, including mid-WAIT and mid-HOLD.
- Outputs `imem_req`, `inst_valid` and `fault` decode the state register only. No combinational path from any input to any output.
- Best case is 3 cycles per instruction:
  - FETCH accepted at cycle N.
  - `imem_rvalid` at N+1.
  - HOLD at N+2, with retire at N+2.
  - FETCH of next_pc at N+3.
- Memory stalls extend FETCH (`imem_ready`=0) or WAIT (`imem_rvalid`=0) indefinitely. Downstream stalls extend HOLD.
- `imem_rvalid` in the same cycle a request is accepted is not a legal response and is ignored.

## Test plan
- Reset release, `imem_ready`=1, rvalid one cycle later with 0x0000_0020 (add), `inst_ready`=1, ctl=00:
  - `imem_addr` sequence 0x0040_0000 then 0x0040_0004.
  - `inst_valid` high exactly one cycle, with `funct`=6'h20.
- Branch: `inst`=0x1000_FFFF at 0x0040_0000, ctl=01 → next fetch address 0x0040_0000. Then imm 0x0003, ctl=01 → 0x0040_0010.
- Jump: `inst_pc`=0x0040_0010, `inst`=0x0810_0008, ctl=10 → next fetch 0x0040_0020. Also `inst_pc`=0xFFFF_FFFC, ctl=00 → next fetch 0x0000_0000 (wrap).
- jr: `rs_data`=0x0040_0100 → fetch 0x0040_0100. `rs_data`=0x0040_0102 → `fault`=1, `imem_req` stays 0 for 10 cycles, `pc` unchanged. Then `reset` → `fault`=0, fetch at 0x0040_0000.
- Stalls:
  - `imem_ready` low 4 cycles → `imem_addr` constant, single acceptance.
  - `imem_rvalid` delayed 5 cycles → no `inst_valid` until the cycle after rvalid.
  - `inst_ready` low 3 cycles in HOLD → `inst` and `inst_pc` stable, no `imem_req`.
- Reset asserted in WAIT, rvalid with 0xDEAD_BEEF in the first post-reset cycle → ignored, `inst_valid`=0, new request to 0x0040_0000.
